// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART transmit- and receive-side
// flow control blocks.
//   XON_CODE / XOFF_CODE : in-band software flow control bytes
//   tx_state_t           : transmit-control FSM state encoding
//   is_ctrl_code()       : true for a byte that collides with XON/XOFF
package uart_pkg;

    localparam logic [7:0] XON_CODE  = 8'd17;
    localparam logic [7:0] XOFF_CODE = 8'd19;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_t;

    function automatic logic is_ctrl_code(input logic [7:0] b);
        return (b == XON_CODE) || (b == XOFF_CODE);
    endfunction

endpackage

// File: rtl/sync_fifo8.sv
// sync_fifo8: single-clock byte FIFO, DEPTH entries (power of two).
// Ports:
//   clk       in  : clock
//   reset     in  : asynchronous active-low reset (pointers and count only)
//   push      in  : write push_data this cycle (caller guarantees !full)
//   push_data in  : byte to store
//   pop       in  : advance read pointer (caller guarantees !empty)
//   pop_data  out : byte at the head of the FIFO (combinational)
//   full      out : count == DEPTH
//   empty     out : count == 0
module sync_fifo8 #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;

    // Storage is not reset; clearing the pointers and count discards contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/flow_tx_ctrl.sv
// flow_tx_ctrl: UART transmit controller with XON/XOFF software flow control.
// Host bytes are queued in a FIFO and handed to the serializer one at a time;
// XON/XOFF control bytes are injected ahead of data according to the local
// receive-buffer level.
// Ports:
//   clk         in  : clock
//   reset       in  : asynchronous active-low reset
//   wr_en       in  : host write strobe
//   wr_data     in  : host byte
//   full        out : transmit FIFO full
//   rx_level    in  : local receive buffer occupancy
//   remote_xon  in  : peer allows data bytes
//   tx_busy     in  : serializer busy
//   tx_write_en out : one-cycle serializer load strobe
//   tx_data     out : byte to serializer
//   local_off   out : last control byte sent was XOFF
//   err         out : sticky; [0] write while full, [1] host byte was XON/XOFF
module flow_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned HI_WM = 6,
    parameter int unsigned LO_WM = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    input  logic [3:0] rx_level,
    input  logic       remote_xon,
    input  logic       tx_busy,
    output logic       tx_write_en,
    output logic [7:0] tx_data,
    output logic       local_off,
    output logic [1:0] err
);

    localparam logic [3:0] HI_LVL = 4'(HI_WM);
    localparam logic [3:0] LO_LVL = 4'(LO_WM);

    // Assert asynchronously, release two clocks after the pin deasserts.
    logic [1:0] rst_sync;
    logic       rst_int;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int = rst_sync[1];

    tx_state_t  state;
    logic       ctrl_pend;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       push;
    logic       pop;
    logic       ctrl_go;
    logic       hi_hit;
    logic       lo_hit;

    assign hi_hit  = (rx_level >= HI_LVL);
    assign lo_hit  = (rx_level <= LO_LVL);
    assign push    = wr_en && !full && !is_ctrl_code(wr_data);
    // A pending control byte always wins over data.
    assign ctrl_go = (state == IDLE) && !tx_busy && ctrl_pend;
    assign pop     = (state == IDLE) && !tx_busy && !ctrl_pend && !fifo_empty && remote_xon;

    sync_fifo8 #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (rst_int),
        .push      (push),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            state       <= IDLE;
            tx_write_en <= 1'b0;
            tx_data     <= 8'h00;
            local_off   <= 1'b0;
            ctrl_pend   <= 1'b0;
            err         <= 2'b00;
        end else begin
            err <= err | {wr_en && is_ctrl_code(wr_data), wr_en && full};

            // The pending bit means XOFF while local_off=0 and XON while
            // local_off=1; reaching the opposite watermark cancels it.
            if (ctrl_go) begin
                ctrl_pend <= 1'b0;
            end else if (!local_off) begin
                if (hi_hit) begin
                    ctrl_pend <= 1'b1;
                end else if (lo_hit) begin
                    ctrl_pend <= 1'b0;
                end
            end else begin
                if (lo_hit) begin
                    ctrl_pend <= 1'b1;
                end else if (hi_hit) begin
                    ctrl_pend <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (ctrl_go) begin
                        tx_data     <= local_off ? XON_CODE : XOFF_CODE;
                        tx_write_en <= 1'b1;
                        local_off   <= !local_off;
                        state       <= LOAD;
                    end else if (pop) begin
                        tx_data     <= fifo_data;
                        tx_write_en <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    tx_write_en <= 1'b0;
                    state       <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flow_tx_ctrl.sv
module tb_flow_tx_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic [3:0] rx_level = 4'd0;
    logic       remote_xon = 1'b0;
    logic       tx_busy;
    logic       tx_write_en;
    logic [7:0] tx_data;
    logic       local_off;
    logic [1:0] err;

    logic ser_busy = 1'b0;
    logic force_busy = 1'b0;
    logic ser_en = 1'b0;
    assign tx_busy = ser_busy | force_busy;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cur_exp = 8'h00;
    logic       prev_we = 1'b0;

    flow_tx_ctrl #(
        .DEPTH (8),
        .HI_WM (6),
        .LO_WM (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .rx_level    (rx_level),
        .remote_xon  (remote_xon),
        .tx_busy     (tx_busy),
        .tx_write_en (tx_write_en),
        .tx_data     (tx_data),
        .local_off   (local_off),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; the byte is captured at the following posedge.
    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("drain_all_emitted", exp_q.size(), 0);
        repeat (12) @(negedge clk);
    endtask

    // Scoreboard monitor: every strobe must match the next expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_write_en) begin
                checks++;
                if (prev_we) begin
                    failures++;
                    $display("FAIL strobe_width: strobe high two cycles, data 0x%0h", tx_data);
                end else if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe: got 0x%0h expected none", tx_data);
                end else begin
                    cur_exp = exp_q.pop_front();
                    if (tx_data !== cur_exp) begin
                        failures++;
                        $display("FAIL tx_byte: got 0x%0h expected 0x%0h", tx_data, cur_exp);
                    end
                end
            end
            prev_we = tx_write_en;
        end
    end

    // Serializer model: random start delay and busy length; data must hold.
    initial begin
        forever begin
            @(negedge clk);
            if (ser_en && tx_write_en) begin
                repeat ($urandom_range(1, 2)) @(negedge clk);
                ser_busy = 1'b1;
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    chk("tx_data_stable", tx_data, cur_exp);
                end
                ser_busy = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic       we;

        // Reset state, checked while reset is held.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_write_en", tx_write_en, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_full", full, 0);
        chk("rst_local_off", local_off, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        reset = 1'b1;
        ser_en = 1'b1;
        repeat (5) @(negedge clk);

        // Latency: write in cycle N, strobe in N+2, one cycle wide.
        remote_xon = 1'b1;
        exp_q.push_back(8'h41);
        write_byte(8'h41);
        chk("lat_n1_no_strobe", tx_write_en, 0);
        @(negedge clk);
        chk("lat_n2_strobe", tx_write_en, 1);
        chk("lat_n2_data", tx_data, 8'h41);
        @(negedge clk);
        chk("lat_n3_low", tx_write_en, 0);
        drain();

        // Fill with peer stopped, overflow, then release.
        remote_xon = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b = 8'h60 + 8'(i);
            exp_q.push_back(b);
            write_byte(b);
        end
        chk("fill_full", full, 1);
        write_byte(8'h99);
        chk("ovf_err", err, 2'b01);
        chk("ovf_still_full", full, 1);
        repeat (10) @(negedge clk);
        remote_xon = 1'b1;
        drain();
        chk("after_drain_full", full, 0);

        // Ramp up: one XOFF; ramp down: one XON.
        exp_q.push_back(8'h13);
        for (int l = 0; l <= 6; l++) begin
            rx_level = 4'(l);
            @(negedge clk);
        end
        drain();
        chk("ramp_up_local_off", local_off, 1);
        exp_q.push_back(8'h11);
        for (int l = 6; l >= 2; l--) begin
            rx_level = 4'(l);
            @(negedge clk);
        end
        drain();
        chk("ramp_down_local_off", local_off, 0);

        // Pending XOFF beats queued data.
        force_busy = 1'b1;
        exp_q.push_back(8'h13);
        for (int i = 0; i < 3; i++) begin
            b = 8'h31 + 8'(i);
            exp_q.push_back(b);
            write_byte(b);
        end
        rx_level = 4'd6;
        repeat (3) @(negedge clk);
        force_busy = 1'b0;
        drain();
        chk("prio_local_off", local_off, 1);
        exp_q.push_back(8'h11);
        rx_level = 4'd2;
        drain();
        chk("prio_back_on", local_off, 0);

        // Request cancelled while serializer busy.
        force_busy = 1'b1;
        rx_level = 4'd6;
        repeat (3) @(negedge clk);
        rx_level = 4'd2;
        repeat (3) @(negedge clk);
        force_busy = 1'b0;
        repeat (15) @(negedge clk);
        chk("cancel_local_off", local_off, 0);

        // Random data with toggling remote_xon, level between watermarks.
        rx_level = 4'd4;
        for (int i = 0; i < 300; i++) begin
            we = ($urandom_range(0, 1) == 1);
            b = 8'($urandom_range(0, 255));
            if (b == 8'd17 || b == 8'd19) b = 8'h20;
            we = we && !full;
            if (we) exp_q.push_back(b);
            wr_en = we;
            wr_data = b;
            if ($urandom_range(0, 7) == 0) remote_xon = ~remote_xon;
            @(negedge clk);
        end
        wr_en = 1'b0;
        remote_xon = 1'b1;
        drain();
        chk("rand_full_clear", full, 0);

        // Host byte colliding with XOFF is rejected.
        write_byte(8'd19);
        repeat (10) @(negedge clk);
        chk("ctrl_byte_err", err, 2'b11);

        // Reset in WAIT_DONE with 5 bytes queued.
        ser_en = 1'b0;
        remote_xon = 1'b0;
        rx_level = 4'd4;
        exp_q.push_back(8'h50);
        for (int i = 0; i < 6; i++) begin
            write_byte(8'h50 + 8'(i));
        end
        remote_xon = 1'b1;
        repeat (4) @(negedge clk);
        force_busy = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_queued", exp_q.size(), 0);
        reset = 1'b0;
        #1;
        chk("mid_rst_write_en", tx_write_en, 0);
        chk("mid_rst_tx_data", tx_data, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_full", full, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        force_busy = 1'b0;
        repeat (30) @(negedge clk);
        chk("post_rst_full", full, 0);
        chk("post_rst_write_en", tx_write_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flow_tx_ctrl.md
FLOW_TX_CTRL -- requirements
Module: flow_tx_ctrl

Interface
REQ-001 SHALL take parameter DEPTH, default 8: transmit FIFO depth in bytes; power of two.
REQ-002 SHALL take parameter HI_WM, default 6: local receive level at which XOFF is requested.
REQ-003 SHALL take parameter LO_WM, default 2: local receive level at which XON is requested; LO_WM < HI_WM.
REQ-004 SHALL provide port clk  in  1: single clock; all state on its rising edge.
REQ-005 SHALL provide port reset  in  1: asynchronous, active-low reset.
REQ-006 SHALL provide port wr_en  in  1: host write strobe, one byte per cycle.
REQ-007 SHALL provide port wr_data  in  8: host byte.
REQ-008 SHALL provide port full  out  1: FIFO count == DEPTH.
REQ-009 SHALL provide port rx_level  in  4: occupancy of the local receive buffer, 0..8.
REQ-010 SHALL provide port remote_xon  in  1: peer permits data, decoded from peer's XON/XOFF.
REQ-011 SHALL provide port tx_busy  in  1: serializer busy.
REQ-012 SHALL provide port tx_write_en  out  1: single-cycle serializer load strobe.
REQ-013 SHALL provide port tx_data  out  8: byte to serializer, stable from the strobe until busy falls.
REQ-014 SHALL provide port local_off  out  1: high while the last control code sent was XOFF.
REQ-015 SHALL provide port err  out  2: sticky; [0] write while full, [1] host byte equal to 17 or 19.

Function
REQ-016 SHALL drop any write while full or with wr_data 17/19 (no FIFO change), setting err[0]/err[1] respectively.
REQ-017 SHALL evaluate full from the registered count; a same-cycle pop SHALL NOT admit a write at full.
REQ-018 SHALL wrap 3-bit read/write pointers modulo DEPTH; the count is 4 bits.
REQ-019 SHALL use FSM states IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-020 IDLE: with tx_busy=0, pending control SHALL win, else pop data if FIFO non-empty and remote_xon=1, then go to LOAD; otherwise stay.
REQ-021 LOAD: tx_write_en=1 for exactly one cycle with tx_data valid, then go to WAIT_BUSY.
REQ-022 WAIT_BUSY: go to WAIT_DONE on tx_busy=1.
REQ-023 WAIT_DONE: go to IDLE on tx_busy=0.
REQ-024 Byte written in cycle N into an empty FIFO, with FSM IDLE, remote_xon=1, tx_busy=0 and no pending control, SHALL strobe tx_write_en in cycle N+2.
REQ-025 rx_level >= HI_WM with local_off=0 SHALL set a pending XOFF (code 19).
REQ-026 rx_level <= LO_WM with local_off=1 SHALL set a pending XON (code 17).
REQ-027 If the level returns to the opposite watermark before the pending code is loaded, the pending request SHALL be cancelled.
REQ-028 local_off SHALL update in the LOAD cycle of a control byte.
REQ-029 Control codes SHALL be sent regardless of remote_xon.
REQ-030 remote_xon falling SHALL NOT abort a byte already in LOAD or later; it only blocks the next data pop.
REQ-031 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged.

Reset
REQ-032 reset low SHALL immediately clear the FSM (to IDLE), pointers, count, pending request, local_off and err.
REQ-033 reset low SHALL also force tx_write_en=0 and tx_data=0.
REQ-034 Assertion mid-transfer SHALL discard all FIFO contents; no strobe SHALL follow release until new stimulus.
REQ-035 Reset release SHALL be synchronized internally (two-flop deassertion).

Structure
REQ-036 Package uart_pkg SHALL hold XON_CODE=17, XOFF_CODE=19 and the FSM state enum, shared with the receive-side control.
REQ-037 FIFO storage and pointers SHALL live in one sub-module sync_fifo8; FSM and watermark logic stay at top level.

Verification
REQ-038 Write 0x41 to an empty FIFO, idle serializer -> tx_write_en in cycle N+2 with tx_data=0x41, one cycle wide.
REQ-039 Fill 8 bytes with remote_xon=0, write a 9th -> full=1, err[0]=1, no strobe; raise remote_xon -> all 8 bytes emitted in order.
REQ-040 Ramp rx_level 0->6 -> one 0x13 strobe, local_off=1; ramp 6->2 -> one 0x11 strobe, local_off=0.
REQ-041 FIFO holds 3 bytes, pending XOFF -> 0x13 emitted before the first data byte.
REQ-042 rx_level 6 then 2 while tx_busy held high -> no control byte sent, local_off stays 0.
REQ-043 Assert reset during WAIT_DONE with 5 bytes queued -> outputs zero at once; after release, no strobe and full=0.
